// File: rtl/vram_sync_ctrl_pkg.sv
// Shared types and constants for the VRAM sync controller: FSM state encoding,
// the default copy timeout and a decoder for the state-derived outputs.
package vram_sync_ctrl_pkg;

    localparam int TIMEOUT_CYCLES_DEFAULT = 4096;
    localparam int SYNC_COUNT_W           = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        ISSUE   = 2'd2,
        BUSY    = 2'd3
    } state_t;

    // Outputs that depend only on which state the FSM is in.
    typedef struct packed {
        logic sync;
        logic cpu_wr_block;
        logic sync_pending;
    } state_out_t;

    function automatic state_out_t decode_state(state_t s);
        state_out_t o;
        o.sync         = (s == ISSUE);
        o.cpu_wr_block = (s == ISSUE) || (s == BUSY);
        o.sync_pending = (s == PENDING);
        return o;
    endfunction

endpackage

// File: rtl/vram_sync_ctrl_if.sv
// Bundle of the CPU request, video timing, sync-writer handshake and status
// signals around the VRAM sync controller. The controller side is the master.
interface vram_sync_ctrl_if;
    import vram_sync_ctrl_pkg::*;

    // CPU / video timing / writer -> controller
    logic                    cpu_sync_req;
    logic                    vblank;
    logic                    vblank_start;
    logic                    sync_done;
    logic                    err_clr;

    // controller -> writer / CPU
    logic                    sync;
    logic                    cpu_wr_block;
    logic                    sync_pending;
    logic                    sync_complete;
    logic                    err_timeout;
    logic                    err_tear;
    logic [SYNC_COUNT_W-1:0] sync_count;

    modport master (
        input  cpu_sync_req, vblank, vblank_start, sync_done, err_clr,
        output sync, cpu_wr_block, sync_pending, sync_complete,
               err_timeout, err_tear, sync_count
    );

    modport slave (
        output cpu_sync_req, vblank, vblank_start, sync_done, err_clr,
        input  sync, cpu_wr_block, sync_pending, sync_complete,
               err_timeout, err_tear, sync_count
    );

endinterface

// File: rtl/vram_sync_ctrl.sv
// VRAM sync controller: latches a CPU copy request, issues a one-cycle sync
// pulse to the VRAM sync writer at the next vblank, watches the copy for
// completion, timeout and tearing, and reports status. All outputs are
// registered; state-derived outputs are decoded from next_state so they line
// up with the state register. TIMEOUT_CYCLES must be at least 2.
module vram_sync_ctrl
    import vram_sync_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    vram_sync_ctrl_if.master  bus
);

    localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state;
    state_t           next_state;
    state_out_t       next_out;
    logic [CNT_W-1:0] cnt;
    logic             deferred;

    logic in_busy;
    logic done_ok;
    logic timed_out;
    logic tear;
    logic req_defer;
    logic busy_exit;
    logic defer_any;

    // The counter is cleared on entry to ISSUE and runs through ISSUE and BUSY,
    // so it reads k on the k-th BUSY cycle and the timeout lands exactly
    // TIMEOUT_CYCLES cycles after the sync pulse. Completion beats timeout.
    assign in_busy   = (state == BUSY);
    assign done_ok   = in_busy && bus.sync_done;
    assign timed_out = in_busy && !bus.sync_done && (cnt == CNT_LAST);
    assign tear      = in_busy && !bus.vblank;
    assign req_defer = bus.cpu_sync_req && ((state == ISSUE) || (state == BUSY));
    assign busy_exit = done_ok || timed_out;
    // A request arriving in the very cycle BUSY exits must not be lost.
    assign defer_any = deferred || req_defer;

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of process ordering.
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: the default assignment up front keeps every path assigned, so
        // no latch is inferred.
        next_state = state;
        case (state)
            IDLE: begin
                if (bus.cpu_sync_req) begin
                    next_state = bus.vblank_start ? ISSUE : PENDING;
                end
            end
            PENDING: begin
                if (bus.vblank_start) begin
                    next_state = ISSUE;
                end
            end
            ISSUE: begin
                next_state = BUSY;
            end
            BUSY: begin
                if (busy_exit) begin
                    next_state = defer_any ? PENDING : IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // State-derived output decode, taken from next_state so it can be registered.
    always_comb begin
        next_out = decode_state(next_state);
    end

    // Timeout counter and deferred-request bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            deferred <= 1'b0;
        end else begin
            if (next_state == ISSUE) begin
                cnt <= '0;
            end else if ((state == ISSUE) || (state == BUSY)) begin
                cnt <= cnt + CNT_W'(1);
            end

            if (busy_exit) begin
                deferred <= 1'b0;
            end else if (req_defer) begin
                deferred <= 1'b1;
            end
        end
    end

    // Registered outputs, completion counter and sticky error flags (set beats clear).
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.sync          <= 1'b0;
            bus.cpu_wr_block  <= 1'b0;
            bus.sync_pending  <= 1'b0;
            bus.sync_complete <= 1'b0;
            bus.err_timeout   <= 1'b0;
            bus.err_tear      <= 1'b0;
            bus.sync_count    <= '0;
        end else begin
            bus.sync          <= next_out.sync;
            bus.cpu_wr_block  <= next_out.cpu_wr_block;
            bus.sync_pending  <= next_out.sync_pending;
            bus.sync_complete <= done_ok;

            if (done_ok) begin
                bus.sync_count <= bus.sync_count + SYNC_COUNT_W'(1);
            end

            if (timed_out) begin
                bus.err_timeout <= 1'b1;
            end else if (bus.err_clr) begin
                bus.err_timeout <= 1'b0;
            end

            if (tear) begin
                bus.err_tear <= 1'b1;
            end else if (bus.err_clr) begin
                bus.err_tear <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_vram_sync_ctrl.sv
// Self-checking bench for vram_sync_ctrl: a cycle-by-cycle vector table run
// through a scoreboard queue, followed by hand-written multi-cycle sequences.
// A second instance with a short timeout covers the timeout corner cases.
module tb_vram_sync_ctrl;
    import vram_sync_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    vram_sync_ctrl_if bus ();
    vram_sync_ctrl_if bus_to ();

    vram_sync_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    vram_sync_ctrl #(.TIMEOUT_CYCLES(64)) dut_to (
        .clk (clk),
        .rst (rst),
        .bus (bus_to.master)
    );

    typedef struct packed {
        logic rst;
        logic req;
        logic vbs;
        logic vbl;
        logic done;
        logic clr;
    } in_t;

    typedef struct packed {
        logic        sync;
        logic        wrb;
        logic        pend;
        logic        comp;
        logic        eto;
        logic        etr;
        logic [15:0] cnt;
    } out_t;

    typedef struct packed {
        in_t  in;
        out_t exp;
    } vec_t;

    vec_t vecs[$];
    out_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic out_t sample_main();
        out_t o;
        o.sync = bus.sync;
        o.wrb  = bus.cpu_wr_block;
        o.pend = bus.sync_pending;
        o.comp = bus.sync_complete;
        o.eto  = bus.err_timeout;
        o.etr  = bus.err_tear;
        o.cnt  = bus.sync_count;
        return o;
    endfunction

    function automatic vec_t mk(
        input logic rs, input logic rq, input logic vs, input logic vl,
        input logic dn, input logic cl,
        input logic sy, input logic wb, input logic pn, input logic cp,
        input logic to, input logic tr, input int cn
    );
        vec_t v;
        v.in  = '{rst: rs, req: rq, vbs: vs, vbl: vl, done: dn, clr: cl};
        v.exp = '{sync: sy, wrb: wb, pend: pn, comp: cp, eto: to, etr: tr, cnt: 16'(cn)};
        return v;
    endfunction

    task automatic apply(input in_t v);
        rst              = v.rst;
        bus.cpu_sync_req = v.req;
        bus.vblank_start = v.vbs;
        bus.vblank       = v.vbl;
        bus.sync_done    = v.done;
        bus.err_clr      = v.clr;
    endtask

    task automatic idle_inputs();
        bus.cpu_sync_req    = 1'b0;
        bus.vblank_start    = 1'b0;
        bus.vblank          = 1'b1;
        bus.sync_done       = 1'b0;
        bus.err_clr         = 1'b0;
        bus_to.cpu_sync_req = 1'b0;
        bus_to.vblank_start = 1'b0;
        bus_to.vblank       = 1'b1;
        bus_to.sync_done    = 1'b0;
        bus_to.err_clr      = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Start a copy on the main instance: request and vblank_start together.
    task automatic start_main();
        bus.cpu_sync_req = 1'b1;
        bus.vblank_start = 1'b1;
        tick();
        bus.cpu_sync_req = 1'b0;
        bus.vblank_start = 1'b0;
    endtask

    task automatic start_to();
        bus_to.cpu_sync_req = 1'b1;
        bus_to.vblank_start = 1'b1;
        tick();
        bus_to.cpu_sync_req = 1'b0;
        bus_to.vblank_start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        out_t got;
        out_t exp;
        int   bad;
        int   first_bad;
        int   seen_comp;

        rst = 1'b1;
        idle_inputs();
        @(negedge clk);

        //         rst req vbs vbl dn clr | sync wrb pend comp eto etr cnt
        vecs.push_back(mk(1, 0, 0, 1, 0, 0,   0, 0, 0, 0, 0, 0, 0)); // reset
        vecs.push_back(mk(0, 0, 0, 1, 0, 0,   0, 0, 0, 0, 0, 0, 0)); // idle
        vecs.push_back(mk(0, 1, 1, 1, 0, 0,   1, 1, 0, 0, 0, 0, 0)); // req+vbs -> ISSUE
        vecs.push_back(mk(0, 0, 0, 1, 0, 0,   0, 1, 0, 0, 0, 0, 0)); // BUSY
        vecs.push_back(mk(0, 1, 0, 1, 0, 0,   0, 1, 0, 0, 0, 0, 0)); // req in BUSY deferred
        vecs.push_back(mk(0, 0, 0, 1, 1, 0,   0, 0, 1, 1, 0, 0, 1)); // done -> PENDING
        vecs.push_back(mk(0, 1, 0, 1, 0, 0,   0, 0, 1, 0, 0, 0, 1)); // coalesce
        vecs.push_back(mk(0, 1, 0, 1, 0, 0,   0, 0, 1, 0, 0, 0, 1)); // coalesce
        vecs.push_back(mk(0, 0, 1, 1, 0, 0,   1, 1, 0, 0, 0, 0, 1)); // vbs -> ISSUE
        vecs.push_back(mk(0, 0, 0, 1, 1, 0,   0, 1, 0, 0, 0, 0, 1)); // done in ISSUE ignored
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 1, 1)); // tear
        vecs.push_back(mk(0, 0, 0, 1, 0, 1,   0, 1, 0, 0, 0, 0, 1)); // clear tear
        vecs.push_back(mk(0, 0, 0, 0, 0, 1,   0, 1, 0, 0, 0, 1, 1)); // tear beats clear
        vecs.push_back(mk(0, 0, 0, 1, 1, 0,   0, 0, 0, 1, 0, 1, 2)); // done -> IDLE
        vecs.push_back(mk(0, 0, 0, 1, 0, 1,   0, 0, 0, 0, 0, 0, 2)); // clear in IDLE
        vecs.push_back(mk(0, 0, 0, 1, 1, 0,   0, 0, 0, 0, 0, 0, 2)); // done in IDLE ignored
        vecs.push_back(mk(0, 1, 0, 1, 0, 0,   0, 0, 1, 0, 0, 0, 2)); // req -> PENDING
        vecs.push_back(mk(0, 1, 0, 1, 0, 0,   0, 0, 1, 0, 0, 0, 2)); // coalesce
        vecs.push_back(mk(0, 1, 1, 1, 0, 0,   1, 1, 0, 0, 0, 0, 2)); // req+vbs in PENDING
        vecs.push_back(mk(0, 1, 0, 1, 0, 0,   0, 1, 0, 0, 0, 0, 2)); // req in ISSUE deferred
        vecs.push_back(mk(0, 0, 0, 1, 1, 0,   0, 0, 1, 1, 0, 0, 3)); // done -> PENDING
        vecs.push_back(mk(0, 0, 0, 1, 0, 0,   0, 0, 1, 0, 0, 0, 3)); // waiting
        vecs.push_back(mk(1, 0, 0, 1, 0, 0,   0, 0, 0, 0, 0, 0, 0)); // reset in PENDING
        vecs.push_back(mk(0, 0, 1, 1, 0, 0,   0, 0, 0, 0, 0, 0, 0)); // vbs alone: no copy

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i].in);
            sb.push_back(vecs[i].exp);
            tick();
            got = sample_main();
            exp = sb.pop_front();
            check($sformatf("vec%0d", i), 32'(got), 32'(exp));
        end

        // Reference trace: req at 5, vblank_start at 20, sync_done at 2100.
        do_reset();
        bad       = 0;
        first_bad = -1;
        for (int c = 0; c <= 2102; c++) begin
            int o;
            out_t e;
            o = c + 1;
            bus.cpu_sync_req = (c == 5);
            bus.vblank_start = (c == 20);
            bus.sync_done    = (c == 2100);
            e      = '0;
            e.pend = (o >= 6) && (o <= 20);
            e.sync = (o == 21);
            e.wrb  = (o >= 21) && (o <= 2100);
            e.comp = (o == 2101);
            e.cnt  = (o >= 2101) ? 16'd1 : 16'd0;
            sb.push_back(e);
            tick();
            got = sample_main();
            exp = sb.pop_front();
            if (got !== exp) begin
                bad++;
                if (first_bad < 0) first_bad = o;
            end
        end
        idle_inputs();
        check("trace_bad_cycles", 32'(bad), 32'd0);
        if (first_bad >= 0) $display("  trace first diverges at cycle %0d", first_bad);
        check("trace_sync_count", 32'(bus.sync_count), 32'd1);

        // Timeout: no sync_done, TIMEOUT_CYCLES = 64.
        do_reset();
        start_to();
        check("to_sync_pulse", 32'(bus_to.sync), 32'd1);
        seen_comp = 0;
        for (int k = 1; k <= 64; k++) begin
            tick();
            if (bus_to.sync_complete) seen_comp++;
            if (k == 63) begin
                check("to_wrb_before", 32'(bus_to.cpu_wr_block), 32'd1);
                check("to_err_before", 32'(bus_to.err_timeout), 32'd0);
            end
            if (k == 64) begin
                check("to_err_at_64", 32'(bus_to.err_timeout), 32'd1);
                check("to_wrb_at_64", 32'(bus_to.cpu_wr_block), 32'd0);
            end
        end
        check("to_no_complete", 32'(seen_comp), 32'd0);
        check("to_count_zero", 32'(bus_to.sync_count), 32'd0);
        tick();
        check("to_err_sticky", 32'(bus_to.err_timeout), 32'd1);
        bus_to.err_clr = 1'b1;
        tick();
        bus_to.err_clr = 1'b0;
        check("to_err_cleared", 32'(bus_to.err_timeout), 32'd0);

        // sync_done in the timeout cycle: completion wins.
        do_reset();
        start_to();
        for (int k = 1; k <= 63; k++) tick();
        bus_to.sync_done = 1'b1;
        tick();
        bus_to.sync_done = 1'b0;
        check("race_complete", 32'(bus_to.sync_complete), 32'd1);
        check("race_no_err", 32'(bus_to.err_timeout), 32'd0);
        check("race_count", 32'(bus_to.sync_count), 32'd1);

        // Request during BUSY -> PENDING after done -> second copy.
        do_reset();
        start_main();
        tick(); tick(); tick();
        bus.cpu_sync_req = 1'b1;
        tick();
        bus.cpu_sync_req = 1'b0;
        tick(); tick();
        bus.sync_done = 1'b1;
        tick();
        bus.sync_done = 1'b0;
        check("defer_complete", 32'(bus.sync_complete), 32'd1);
        check("defer_pending", 32'(bus.sync_pending), 32'd1);
        check("defer_wrb_low", 32'(bus.cpu_wr_block), 32'd0);
        tick(); tick(); tick();
        check("defer_still_pending", 32'(bus.sync_pending), 32'd1);
        bus.vblank_start = 1'b1;
        tick();
        bus.vblank_start = 1'b0;
        check("defer_second_sync", 32'(bus.sync), 32'd1);
        tick();
        bus.sync_done = 1'b1;
        tick();
        bus.sync_done = 1'b0;
        check("defer_count_two", 32'(bus.sync_count), 32'd2);
        check("defer_back_idle", 32'(bus.sync_pending), 32'd0);

        // Tear 100 cycles into BUSY, with err_clr in the same cycle.
        do_reset();
        start_main();
        for (int k = 0; k < 100; k++) tick();
        bus.vblank  = 1'b0;
        bus.err_clr = 1'b1;
        tick();
        bus.vblank  = 1'b1;
        bus.err_clr = 1'b0;
        check("tear_set", 32'(bus.err_tear), 32'd1);
        check("tear_still_busy", 32'(bus.cpu_wr_block), 32'd1);
        for (int k = 0; k < 5; k++) tick();
        check("tear_sticky", 32'(bus.err_tear), 32'd1);
        bus.sync_done = 1'b1;
        tick();
        bus.sync_done = 1'b0;
        check("tear_complete", 32'(bus.sync_complete), 32'd1);
        check("tear_count", 32'(bus.sync_count), 32'd1);

        // Reset mid-BUSY: copy abandoned, no error even with vblank low.
        do_reset();
        start_main();
        for (int k = 0; k < 10; k++) tick();
        rst        = 1'b1;
        bus.vblank = 1'b0;
        tick();
        rst        = 1'b0;
        bus.vblank = 1'b1;
        check("rst_outputs_zero", 32'(sample_main()), 32'd0);
        bus.sync_done = 1'b1;
        tick();
        bus.sync_done = 1'b0;
        check("rst_late_done", 32'(sample_main()), 32'd0);
        tick();
        check("rst_still_idle", 32'(sample_main()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
